// File: rtl/instr_mem_loadable.sv
// instr_mem_loadable: loadable instruction memory for the 19-bit CPU.
// Self-clears after reset, then serves registered 1-cycle fetches with a
// stall/flush handshake and accepts program-load writes.
// Optional feature macro: IMEM_PARITY_EN (per-word even parity, f_perr,
// ld_par_inv error injection).
module instr_mem_loadable #(
  parameter int DATA_W = 19,
  parameter int ADDR_W = 19,
  parameter int DEPTH  = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic              f_stall,
  input  logic              f_flush,
  output logic              f_ready,
  output logic              f_valid,
  output logic [DATA_W-1:0] f_instr,
  output logic              f_fault,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
`ifdef IMEM_PARITY_EN
  input  logic              ld_par_inv,
  output logic              f_perr,
`endif
  output logic              ld_ready,
  output logic              ld_err,
  output logic              init_done
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(DEPTH - 1);
  // one extra bit so DEPTH == 2**ADDR_W still compares correctly
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t             state;
  logic [IDX_W-1:0]   clr_cnt;
  logic [DATA_W-1:0]  mem [DEPTH];
`ifdef IMEM_PARITY_EN
  logic               par_mem [DEPTH];
  logic               wr_par;
`endif

  logic               run, f_in_rng, ld_in_rng, ld_ok, accept, byp;
  logic [IDX_W-1:0]   f_idx, ld_idx, wr_idx;
  logic               wr_en;
  logic [DATA_W-1:0]  wr_data, rd_data;

  assign run       = (state == S_RUN);
  assign f_in_rng  = ({1'b0, f_addr}  < DEPTH_L);
  assign ld_in_rng = ({1'b0, ld_addr} < DEPTH_L);
  assign f_idx     = f_addr[IDX_W-1:0];
  assign ld_idx    = ld_addr[IDX_W-1:0];
  assign ld_ok     = run & ld_en & ld_in_rng;
  assign f_ready   = run & ~(f_valid & f_stall);
  assign accept    = f_req & f_ready;
  // same-cycle load to the fetched address: forward the load data
  assign byp       = ld_ok & (ld_addr == f_addr);
  assign rd_data   = byp ? ld_data : mem[f_idx];
  assign ld_ready  = init_done;

  // sequencer: CLEAR walks every word once, then RUN until next reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_CLEAR;
      clr_cnt   <= '0;
      init_done <= 1'b0;
    end else if (state == S_CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == CNT_LAST) begin
        state     <= S_RUN;
        init_done <= 1'b1;
      end
    end
  end

  // single write port shared by the clear sweep and program loads
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = ld_idx;
    wr_data = ld_data;
`ifdef IMEM_PARITY_EN
    wr_par  = (^ld_data) ^ ld_par_inv;
`endif
    if (rst && state == S_CLEAR) begin
      wr_en   = 1'b1;
      wr_idx  = clr_cnt;
      wr_data = '0;
`ifdef IMEM_PARITY_EN
      wr_par  = 1'b0;
`endif
    end else if (rst && ld_ok) begin
      wr_en = 1'b1;
    end
  end

  // storage array
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
`ifdef IMEM_PARITY_EN
      par_mem[wr_idx] <= wr_par;
`endif
    end
  end

  // fetch output register and load error pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      f_valid <= 1'b0;
      f_instr <= '0;
      f_fault <= 1'b0;
      ld_err  <= 1'b0;
`ifdef IMEM_PARITY_EN
      f_perr  <= 1'b0;
`endif
    end else begin
      ld_err <= run & ld_en & ~ld_in_rng;
      if (accept) begin
        f_valid <= 1'b1;
        f_instr <= f_in_rng ? rd_data : '0;
        f_fault <= ~f_in_rng;
`ifdef IMEM_PARITY_EN
        if (!f_in_rng)  f_perr <= 1'b0;
        else if (byp)   f_perr <= ld_par_inv;
        else            f_perr <= par_mem[f_idx] ^ (^mem[f_idx]);
`endif
      end else if (f_flush || !f_stall) begin
        // a stalled valid word holds; anything else drops valid
        f_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Self-checking bench for instr_mem_loadable (DEPTH=128). Fetch results are
// predicted from a shadow memory and queued; each delivered word is popped
// and compared. Define IMEM_PARITY_EN to also exercise parity.
module tb_instr_mem_loadable;
  localparam int DW = 19, AW = 19, DEPTH = 128;

  logic          clk = 1'b0;
  logic          rst, f_req, f_stall, f_flush, ld_en;
  logic [AW-1:0] f_addr, ld_addr;
  logic [DW-1:0] ld_data;
  logic          f_ready, f_valid, f_fault, ld_ready, ld_err, init_done;
  logic [DW-1:0] f_instr;
`ifdef IMEM_PARITY_EN
  logic          ld_par_inv, f_perr;
`endif

  instr_mem_loadable #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .f_req(f_req), .f_addr(f_addr), .f_stall(f_stall),
    .f_flush(f_flush), .f_ready(f_ready), .f_valid(f_valid), .f_instr(f_instr),
    .f_fault(f_fault), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
`ifdef IMEM_PARITY_EN
    .ld_par_inv(ld_par_inv), .f_perr(f_perr),
`endif
    .ld_ready(ld_ready), .ld_err(ld_err), .init_done(init_done));

  always #5 clk = ~clk;

  typedef struct { logic [DW-1:0] instr; logic fault; } exp_t;
  exp_t          sb[$];
  logic [DW-1:0] model [DEPTH];
  int            checks = 0, errors = 0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic do_load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    if (a < AW'(DEPTH)) model[a[6:0]] = d;
  endtask

  // drive a fetch expected to be accepted this cycle and queue its result
  task automatic push_fetch(input logic [AW-1:0] a);
    exp_t e;
    f_req = 1'b1; f_addr = a;
    e.fault = (a >= AW'(DEPTH));
    e.instr = e.fault ? '0 : model[a[6:0]];
    sb.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b0; f_req = 1'b1; f_addr = 5; ld_en = 1'b1; ld_addr = 200;
    tick(); tick();
    checks++;
    if ({f_valid, f_fault, ld_err, init_done, f_ready, ld_ready, f_instr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b f=%b le=%b id=%b fr=%b lr=%b i=%h want all 0",
               f_valid, f_fault, ld_err, init_done, f_ready, ld_ready, f_instr);
    end
  endtask

  task automatic test_clear();
    exp_t e;
    int n = 0, bad = 0;
    rst = 1'b1; f_req = 1'b1; f_addr = 3;
    do_load(7, 19'h12345);
    model_clear();
    while (!init_done && n < 400) begin
      tick(); n++;
      if (!init_done && (f_ready !== 1'b0 || ld_ready !== 1'b0 || f_valid !== 1'b0 || ld_err !== 1'b0))
        bad++;
    end
    ld_en = 1'b0;
    checks++;
    if (n !== DEPTH) begin
      errors++; $display("FAIL clear_len got %0d cycles want %0d", n, DEPTH);
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL clear_quiet got %0d active cycles want 0", bad);
    end
    push_fetch(5); #1;
    checks++;
    if (f_ready !== 1'b1 || ld_ready !== 1'b1) begin
      errors++; $display("FAIL run_ready got fr=%b lr=%b want 1 1", f_ready, ld_ready);
    end
    tick(); e = sb.pop_front(); checks++;
    if (f_valid !== 1'b1 || f_instr !== e.instr || f_fault !== e.fault) begin
      errors++; $display("FAIL clear_fetch5 got v=%b i=%h f=%b want 1 %h %b", f_valid, f_instr, f_fault, e.instr, e.fault);
    end
    push_fetch(7);
    tick(); e = sb.pop_front(); checks++;
    if (f_valid !== 1'b1 || f_instr !== e.instr || f_fault !== e.fault) begin
      errors++; $display("FAIL clear_ld_ignored got v=%b i=%h f=%b want 1 %h %b", f_valid, f_instr, f_fault, e.instr, e.fault);
    end
    f_req = 1'b0;
  endtask

  task automatic test_load_fetch();
    exp_t e;
    logic [DW-1:0] last;
    do_load(1, 19'h0950A); push_fetch(1);
    tick(); ld_en = 1'b0; e = sb.pop_front(); checks++;
    if (f_valid !== 1'b1 || f_instr !== 19'h0950A || e.instr !== 19'h0950A) begin
      errors++; $display("FAIL bypass got v=%b i=%h want 1 0950a", f_valid, f_instr);
    end
    push_fetch(1);
    tick(); e = sb.pop_front(); checks++;
    if (f_valid !== 1'b1 || f_instr !== 19'h0950A) begin
      errors++; $display("FAIL load_next got v=%b i=%h want 1 0950a", f_valid, f_instr);
    end
    // streaming: load addr 16+i while fetching the word loaded last cycle
    for (int i = 0; i < 16; i++) begin
      do_load(AW'(16 + i), DW'($urandom));
      push_fetch(AW'(15 + i));
      tick(); e = sb.pop_front(); last = e.instr; checks++;
      if (f_valid !== 1'b1 || f_instr !== e.instr || f_fault !== 1'b0) begin
        errors++; $display("FAIL stream[%0d] got v=%b i=%h f=%b want 1 %h 0", i, f_valid, f_instr, f_fault, e.instr);
      end
    end
    ld_en = 1'b0; f_req = 1'b0;
    tick(); checks++;
    if (f_valid !== 1'b0 || f_instr !== last) begin
      errors++; $display("FAIL idle_hold got v=%b i=%h want 0 %h", f_valid, f_instr, last);
    end
  endtask

  task automatic test_stall_flush();
    exp_t e;
    do_load(0, 19'h2AAAA); tick(); ld_en = 1'b0;
    push_fetch(0);
    tick(); e = sb.pop_front(); checks++;
    if (f_valid !== 1'b1 || f_instr !== e.instr) begin
      errors++; $display("FAIL sf_fetch0 got v=%b i=%h want 1 %h", f_valid, f_instr, e.instr);
    end
    f_stall = 1'b1; f_req = 1'b1; f_addr = 1;
    for (int k = 0; k < 3; k++) begin
      #1; checks++;
      if (f_ready !== 1'b0) begin
        errors++; $display("FAIL stall_ready[%0d] got %b want 0", k, f_ready);
      end
      tick(); checks++;
      if (f_valid !== 1'b1 || f_instr !== model[0]) begin
        errors++; $display("FAIL stall_hold[%0d] got v=%b i=%h want 1 %h", k, f_valid, f_instr, model[0]);
      end
    end
    f_flush = 1'b1; #1; checks++;
    if (f_ready !== 1'b0) begin
      errors++; $display("FAIL flush_ready got %b want 0", f_ready);
    end
    tick(); f_flush = 1'b0; checks++;
    if (f_valid !== 1'b0) begin
      errors++; $display("FAIL flush_valid got %b want 0", f_valid);
    end
    push_fetch(1); #1; checks++;
    if (f_ready !== 1'b1) begin
      errors++; $display("FAIL after_flush_ready got %b want 1", f_ready);
    end
    tick(); e = sb.pop_front(); checks++;
    if (f_valid !== 1'b1 || f_instr !== e.instr) begin
      errors++; $display("FAIL after_flush_fetch got v=%b i=%h want 1 %h", f_valid, f_instr, e.instr);
    end
    // flush together with an accepted fetch: new fetch wins
    f_stall = 1'b0; f_flush = 1'b1; push_fetch(0);
    tick(); f_flush = 1'b0; f_req = 1'b0; e = sb.pop_front(); checks++;
    if (f_valid !== 1'b1 || f_instr !== e.instr) begin
      errors++; $display("FAIL flush_accept got v=%b i=%h want 1 %h", f_valid, f_instr, e.instr);
    end
    tick(); checks++;
    if (f_valid !== 1'b0) begin
      errors++; $display("FAIL drop_valid got %b want 0", f_valid);
    end
  endtask

  task automatic test_out_of_range();
    exp_t e;
    do_load(5, 19'h7FFFF); push_fetch(128);
    tick(); ld_en = 1'b0; e = sb.pop_front(); checks++;
    if (f_valid !== 1'b1 || f_fault !== 1'b1 || f_instr !== 19'h0 || e.fault !== 1'b1) begin
      errors++; $display("FAIL oor128 got v=%b f=%b i=%h want 1 1 0", f_valid, f_fault, f_instr);
    end
    push_fetch(19'h40005);
    tick(); e = sb.pop_front(); checks++;
    if (f_valid !== 1'b1 || f_fault !== 1'b1 || f_instr !== 19'h0) begin
      errors++; $display("FAIL oor_nowrap got v=%b f=%b i=%h want 1 1 0", f_valid, f_fault, f_instr);
    end
    do_load(127, 19'h13579); push_fetch(127);
    tick(); ld_en = 1'b0; f_req = 1'b0; e = sb.pop_front(); checks++;
    if (f_valid !== 1'b1 || f_fault !== 1'b0 || f_instr !== e.instr) begin
      errors++; $display("FAIL top_word got v=%b f=%b i=%h want 1 0 %h", f_valid, f_fault, f_instr, e.instr);
    end
    do_load(200, 19'h55555);
    tick(); ld_en = 1'b0; checks++;
    if (ld_err !== 1'b1) begin
      errors++; $display("FAIL ld_err_pulse got %b want 1", ld_err);
    end
    tick(); checks++;
    if (ld_err !== 1'b0) begin
      errors++; $display("FAIL ld_err_end got %b want 0", ld_err);
    end
    do_load(19'h40003, 19'h11111);
    tick(); do_load(128, 19'h22222); checks++;
    if (ld_err !== 1'b1) begin
      errors++; $display("FAIL ld_err_b2b0 got %b want 1", ld_err);
    end
    tick(); ld_en = 1'b0; checks++;
    if (ld_err !== 1'b1) begin
      errors++; $display("FAIL ld_err_b2b1 got %b want 1", ld_err);
    end
    push_fetch(3);
    tick(); f_req = 1'b0; e = sb.pop_front(); checks++;
    if (ld_err !== 1'b0 || f_instr !== e.instr || f_valid !== 1'b1) begin
      errors++; $display("FAIL bad_ld_nowrite got le=%b i=%h want 0 %h", ld_err, f_instr, e.instr);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int n = 0;
    do_load(2, 19'h0ABCD); tick(); ld_en = 1'b0;
    push_fetch(2);
    tick(); f_req = 1'b0; f_stall = 1'b1; e = sb.pop_front(); checks++;
    if (f_valid !== 1'b1 || f_instr !== e.instr) begin
      errors++; $display("FAIL pre_reset got v=%b i=%h want 1 %h", f_valid, f_instr, e.instr);
    end
    tick(); rst = 1'b0;
    tick(); rst = 1'b1; f_stall = 1'b0; checks++;
    if ({f_valid, f_fault, ld_err, init_done, f_ready, ld_ready, f_instr} !== '0) begin
      errors++; $display("FAIL reset_run got v=%b i=%h id=%b fr=%b want all 0", f_valid, f_instr, init_done, f_ready);
    end
    repeat (60) tick();
    checks++;
    if (init_done !== 1'b0 || f_ready !== 1'b0) begin
      errors++; $display("FAIL mid_clear got id=%b fr=%b want 0 0", init_done, f_ready);
    end
    rst = 1'b0; tick(); rst = 1'b1; checks++;
    if ({f_valid, f_fault, ld_err, init_done, f_ready, ld_ready, f_instr} !== '0) begin
      errors++; $display("FAIL reset_clear got v=%b id=%b fr=%b want all 0", f_valid, init_done, f_ready);
    end
    model_clear();
    while (!init_done && n < 400) begin tick(); n++; end
    checks++;
    if (n !== DEPTH) begin
      errors++; $display("FAIL reclear_len got %0d cycles want %0d", n, DEPTH);
    end
    push_fetch(2);
    tick(); f_req = 1'b0; e = sb.pop_front(); checks++;
    if (f_valid !== 1'b1 || f_instr !== e.instr || e.instr !== 19'h0) begin
      errors++; $display("FAIL reclear_fetch got v=%b i=%h want 1 0", f_valid, f_instr);
    end
  endtask

`ifdef IMEM_PARITY_EN
  task automatic test_parity();
    exp_t e;
    ld_par_inv = 1'b1; do_load(3, 19'h0950A);
    tick(); ld_par_inv = 1'b0; ld_en = 1'b0;
    push_fetch(3);
    tick(); f_req = 1'b0; e = sb.pop_front(); checks++;
    if (f_valid !== 1'b1 || f_instr !== e.instr || f_perr !== 1'b1) begin
      errors++; $display("FAIL perr_inj got v=%b i=%h p=%b want 1 %h 1", f_valid, f_instr, f_perr, e.instr);
    end
    do_load(3, 19'h0950A);
    tick(); ld_en = 1'b0;
    push_fetch(3);
    tick(); f_req = 1'b0; e = sb.pop_front(); checks++;
    if (f_valid !== 1'b1 || f_perr !== 1'b0) begin
      errors++; $display("FAIL perr_clean got v=%b p=%b want 1 0", f_valid, f_perr);
    end
  endtask
`endif

  initial begin
    rst = 1'b0; f_req = 1'b0; f_addr = '0; f_stall = 1'b0; f_flush = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
`ifdef IMEM_PARITY_EN
    ld_par_inv = 1'b0;
`endif
    model_clear();
    tick();
    test_reset();
    test_clear();
    test_load_fetch();
    test_stall_flush();
    test_out_of_range();
    test_reset_mid();
`ifdef IMEM_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
